// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divisor helper.
// Used by both the receive and transmit paths.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // Integer cycles per bit; the remainder is absorbed by mid-bit sampling.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, with a configurable reset value
// so idle-high lines do not produce a false edge out of reset.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 deframing into a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames (sense set by PARITY_ODD) and drive PERR.
//
// Handshake: a byte transfers on any cycle where VALID & READY are both high; DATA is
// stable while VALID=1; READY with VALID=0 has no effect.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 16000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RX,
   output logic [DATA_W-1:0] DATA,
   output logic              VALID,
   input  logic              READY,
   output logic              BUSY,
   output logic              FERR,
   output logic              OVERRUN,
   output logic              PERR,
   output state_t            DBG_STATE
);

   localparam int             CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic              w_rxs;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_bitidx;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_ferr;
   logic              r_ovr;
   logic              r_perr;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [2:0]        w_bitidx_nxt;
   logic [DATA_W-1:0] w_shreg_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_valid_nxt;
   logic              w_deliver;
   logic              w_ferr_nxt;
   logic              w_ovr_nxt;
   logic              w_perr_nxt;

`ifdef UART_RX_PARITY_EN
   logic              r_pmis;
   logic              w_pmis_nxt;
`else
   logic              w_unused_parity;
   assign w_unused_parity = PARITY_ODD;
`endif

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_d     (RX),
      .o_q     (w_rxs)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bitidx <= '0;
         r_shreg  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
         r_perr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_pmis   <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_bitidx <= w_bitidx_nxt;
         r_shreg  <= w_shreg_nxt;
         r_data   <= w_data_nxt;
         r_valid  <= w_valid_nxt;
         r_ferr   <= w_ferr_nxt;
         r_ovr    <= w_ovr_nxt;
         r_perr   <= w_perr_nxt;
`ifdef UART_RX_PARITY_EN
         r_pmis   <= w_pmis_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt + 1'b1;
      w_bitidx_nxt = r_bitidx;
      w_shreg_nxt  = r_shreg;
      w_deliver    = 1'b0;
      w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_pmis_nxt   = r_pmis;
`endif

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rxs) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == CNT_MID) begin
               w_cnt_nxt    = '0;
               w_bitidx_nxt = '0;
               w_state_nxt  = w_rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            // From here on every sample lands mid-bit because START ended mid-bit.
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt    = '0;
               w_shreg_nxt  = {w_rxs, r_shreg[DATA_W-1:1]};
               w_bitidx_nxt = r_bitidx + 3'd1;
               if (r_bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_pmis_nxt  = ((^r_shreg) ^ w_rxs) != PARITY_ODD;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_deliver   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_nxt = '0;
            if (w_rxs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Holding register: a delivery can reuse the slot in the same cycle the old byte leaves.
   always_comb begin
      w_valid_nxt = r_valid & ~READY;
      w_data_nxt  = r_data;
      w_ovr_nxt   = 1'b0;
      if (w_deliver) begin
         if (!r_valid || READY) begin
            w_data_nxt  = r_shreg;
            w_valid_nxt = 1'b1;
         end else begin
            w_ovr_nxt = 1'b1;
         end
      end
`ifdef UART_RX_PARITY_EN
      w_perr_nxt = w_deliver & r_pmis;
`else
      w_perr_nxt = 1'b0;
`endif
   end

   assign DATA      = r_data;
   assign VALID     = r_valid;
   assign BUSY      = (r_state != S_IDLE);
   assign FERR      = r_ferr;
   assign OVERRUN   = r_ovr;
   assign PERR      = r_perr;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames, scoreboards delivered bytes
// and counts error pulses at the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CLK_HZ     = 16000000;
   localparam int BAUD       = 115200;
   localparam int CPB        = clks_per_bit(CLK_HZ, BAUD);
   localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   // RX fall to VALID rise: sync + half start bit + data/parity/stop bits + register.
   localparam int LAT = 2 + CPB / 2 + (9 + int'(PAR_EN)) * CPB + 1;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       ferr;
   logic       overrun;
   logic       perr;
   state_t     dbg_state;

   int         n_checks;
   int         n_errors;
   logic [7:0] exp_q[$];
   int         cyc;
   int         valid_cyc;
   int         ferr_n;
   int         ovr_n;
   int         perr_n;
   int         rise_cyc;
   logic       prev_valid;

   uart_rx #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .CLKS_PER_BIT (CPB),
      .PARITY_ODD   (PARITY_ODD)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .RX        (rx),
      .DATA      (data),
      .VALID     (valid),
      .READY     (ready),
      .BUSY      (busy),
      .FERR      (ferr),
      .OVERRUN   (overrun),
      .PERR      (perr),
      .DBG_STATE (dbg_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      if (PAR_EN) begin
         rx = (^d) ^ PARITY_ODD ^ bad_par;
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (valid) valid_cyc++;
         if (valid && !prev_valid) rise_cyc = cyc;
         if (ferr) ferr_n++;
         if (overrun) ovr_n++;
         if (perr) perr_n++;
         if (valid && ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("data", 32'(data), 32'(exp_q.pop_front()));
         end
         prev_valid <= valid;
      end
   end

   initial begin
      int v0, f0, o0, p0, t_fall;
      n_checks = 0;
      n_errors = 0;
      cyc = 0;
      valid_cyc = 0;
      ferr_n = 0;
      ovr_n = 0;
      perr_n = 0;
      rise_cyc = 0;
      rx = 1'b1;
      ready = 1'b0;
      rst_n = 1'b0;
      tick(4);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", {29'd0, ferr, overrun, perr}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst_n = 1'b1;
      tick(10);

      // Single character with latency measurement.
      ready = 1'b1;
      v0 = valid_cyc; f0 = ferr_n; o0 = ovr_n; p0 = perr_n;
      t_fall = cyc;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      tick(CPB);
      check("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);
      check("a5_flags", 32'((ferr_n - f0) + (ovr_n - o0) + (perr_n - p0)), 32'd0);
      check("a5_latency", 32'(((rise_cyc - t_fall) >= LAT - 1 && (rise_cyc - t_fall) <= LAT + 1)
                              ? LAT : (rise_cyc - t_fall)), 32'(LAT));

      // Start-bit glitch.
      v0 = valid_cyc;
      rx = 1'b0;
      tick(10);
      check("glitch_busy_hi", 32'(busy), 32'd1);
      tick(30);
      rx = 1'b1;
      tick(32);
      check("glitch_busy_lo", 32'(busy), 32'd0);
      check("glitch_state", 32'(dbg_state), 32'(S_IDLE));
      tick(12 * CPB);
      check("glitch_no_valid", 32'(valid_cyc - v0), 32'd0);

      // Framing error followed by a long break, then a clean byte.
      v0 = valid_cyc; f0 = ferr_n;
      send_frame(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      tick(5000);
      check("break_state", 32'(dbg_state), 32'(S_BREAK));
      rx = 1'b1;
      tick(2 * CPB);
      check("ferr_once", 32'(ferr_n - f0), 32'd1);
      check("ferr_no_valid", 32'(valid_cyc - v0), 32'd0);
      check("break_idle", 32'(dbg_state), 32'(S_IDLE));
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1'b0);
      tick(CPB);

      // Overrun: consumer stalled across two back-to-back bytes.
      ready = 1'b0;
      o0 = ovr_n;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      tick(CPB);
      check("ovr_pulse", 32'(ovr_n - o0), 32'd1);
      check("ovr_valid_held", 32'(valid), 32'd1);
      check("ovr_data_kept", 32'(data), 32'h11);
      ready = 1'b1;
      tick(1);
      check("ovr_valid_drop", 32'(valid), 32'd0);
      tick(CPB);

      // READY pulsed exactly in the delivery cycle of the second byte.
      ready = 1'b0;
      o0 = ovr_n;
      exp_q.push_back(8'h33);
      send_frame(8'h33, 1'b1, 1'b0);
      tick(CPB);
      exp_q.push_back(8'h44);
      fork
         send_frame(8'h44, 1'b1, 1'b0);
         begin
            tick(LAT - 1);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
         end
      join
      check("swap_no_ovr", 32'(ovr_n - o0), 32'd0);
      check("swap_valid", 32'(valid), 32'd1);
      check("swap_data", 32'(data), 32'h44);
      ready = 1'b1;
      tick(2);
      check("swap_drained", 32'(valid), 32'd0);

      // Reset in the middle of bit 4 of 0xFF.
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(4 * CPB + CPB / 2);
      check("mid_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {22'd0, data, valid, busy, ferr, overrun, perr}, 32'd0);
      tick(5);
      rst_n = 1'b1;
      tick(6 * CPB);
      check("mid_no_valid", 32'(valid), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      tick(CPB);

`ifdef UART_RX_PARITY_EN
      p0 = perr_n;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      tick(CPB);
      check("par_good", 32'(perr_n - p0), 32'd0);
      p0 = perr_n;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      tick(CPB);
      check("par_bad", 32'(perr_n - p0), 32'd1);
`else
      check("perr_never", 32'(perr_n), 32'd0);
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
